// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: turns the pc block's current PC into one
// memory read at a time and hands each instruction to decode through a
// single-entry valid/ready register. It also drives the pc block's update
// select: boot vector, sequential advance, branch redirect, trap vector.
module fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nextPC,
  output logic [1:0]        nextPCop,
  output logic              intVec,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              trap,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  // BOOT: one cycle of reset vector. ISSUE: may launch a read.
  // WAIT: read in flight, result wanted. DRAIN: read in flight, result dropped.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Encoding of the pc block's update select.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_VEC  = 2'b11
  } pc_op_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  // A redirect or trap kills the fetch stream; both are ignored during BOOT.
  logic flush;
  logic pop;
  assign flush = (state_q != S_BOOT) && (trap || redirect_valid);
  assign pop   = valid_q && inst_ready;

  // Next-state and pc-control decode; every output gets its default first.
  always_comb begin
    // NOTE: assigning every always_comb output a default before any branch is what keeps partial if/case paths from inferring latches.
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    nextPCop = OP_HOLD;
    nextPC   = '0;
    intVec   = 1'b0;

    // Decode consumes the held instruction; a same-cycle fill below overrides.
    if (pop) valid_d = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        nextPCop = OP_VEC;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        // Only launch when the output register will have room for the result.
        if (!flush && (!valid_q || inst_ready)) begin
          req_d   = 1'b1;
          addr_d  = PC;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_ISSUE;
          if (!flush) begin
            nextPCop = OP_INC;
            valid_d  = 1'b1;
            data_d   = imem_rdata;
            ipc_d    = addr_q;
          end
        end else if (flush) begin
          // The read cannot be withdrawn; wait it out and discard the data.
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // Trap outranks redirect; either one empties the output register.
    if (flush) begin
      valid_d = 1'b0;
      if (trap) begin
        nextPCop = OP_VEC;
        intVec   = 1'b1;
      end else begin
        nextPCop = OP_LOAD;
        nextPC   = redirect_target;
      end
    end
  end

  // State and registered outputs; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values, independent of statement order.
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_data  = data_q;
  assign inst_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a transaction-level model of the fetch stream (busy
// flag, kill flag, one-entry output slot) plus a model of the pc block and of
// instruction memory. Expected fetch addresses and delivered instructions go
// into queues; an independent monitor pops them when the DUT shows a new
// request or a decode handshake.
module tb_fetch_ctrl;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] PC;
  logic [AW-1:0] nextPC;
  logic [1:0]    nextPCop;
  logic          intVec;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          trap;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC             (PC),
    .nextPC         (nextPC),
    .nextPCop       (nextPCop),
    .intVec         (intVec),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap           (trap),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Scoreboard queues.
  logic [31:0] exp_req_q[$];
  logic [63:0] exp_inst_q[$];

  // Reference model state.
  bit          m_boot, m_busy, m_killed, m_valid;
  logic [31:0] m_addr, m_pc, m_data;
  logic [31:0] pc_nx;
  int          mem_cnt;
  int          lat_fix;
  bit          spur_en;

  // One clock cycle: drive inputs, check, advance the model.
  task automatic cyc(input bit rv, input logic [31:0] rt, input bit tr, input bit rdy);
    logic        ack;
    logic [31:0] rdata;
    logic [1:0]  e_op;
    logic        e_iv;
    logic [31:0] e_npc;
    bit          flush, pop, fill;
    @(negedge clk);
    PC = pc_nx;
    ack   = 1'b0;
    rdata = $urandom;
    if (m_busy) begin
      if (mem_cnt == 1) begin
        ack   = 1'b1;
        rdata = mem_word(m_addr);
      end
    end else if (spur_en && $urandom_range(9) == 0) begin
      ack = 1'b1;
    end
    imem_ack        = ack;
    imem_rdata      = rdata;
    redirect_valid  = rv;
    redirect_target = rt;
    trap            = tr;
    inst_ready      = rdy;
    #1;
    check("imem_req", 64'(imem_req), 64'(m_busy));
    if (m_busy) check("imem_addr", 64'(imem_addr), 64'(m_addr));
    check("inst_valid", 64'(inst_valid), 64'(m_valid));

    e_iv  = 1'b0;
    e_npc = 32'h0;
    if (m_boot)                        e_op = 2'b11;
    else if (tr) begin                 e_op = 2'b11; e_iv = 1'b1; end
    else if (rv) begin                 e_op = 2'b10; e_npc = rt; end
    else if (m_busy && ack && !m_killed) e_op = 2'b01;
    else                               e_op = 2'b00;
    check("nextPCop", 64'(nextPCop), 64'(e_op));
    check("intVec", 64'(intVec), 64'(e_iv));
    check("nextPC", 64'(nextPC), 64'(e_npc));

    case (e_op)
      2'b00:   pc_nx = PC;
      2'b01:   pc_nx = PC + 32'd4;
      2'b10:   pc_nx = e_npc;
      default: pc_nx = e_iv ? TRAP_VEC : 32'h0;
    endcase

    flush = !m_boot && (tr || rv);
    pop   = m_valid && rdy;
    fill  = m_busy && ack && !m_killed && !flush;
    if (pop) exp_inst_q.push_back({m_pc, m_data});
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_busy) begin
      if (ack) begin
        m_busy   = 1'b0;
        m_killed = 1'b0;
      end else begin
        mem_cnt--;
        if (flush) m_killed = 1'b1;
      end
    end else if (!flush && (!m_valid || rdy)) begin
      m_busy   = 1'b1;
      m_killed = 1'b0;
      m_addr   = PC;
      mem_cnt  = (lat_fix != 0) ? lat_fix : $urandom_range(1, 4);
      exp_req_q.push_back(PC);
    end
    if (pop || flush) m_valid = 1'b0;
    if (fill) begin
      m_valid = 1'b1;
      m_data  = rdata;
      m_pc    = m_addr;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    trap           = 1'b0;
    inst_ready     = 1'b0;
    #1;
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_nextPCop", 64'(nextPCop), 64'd3);
    check("rst_intVec", 64'(intVec), 64'd0);
    check("rst_nextPC", 64'(nextPC), 64'd0);
    m_boot = 1'b1; m_busy = 1'b0; m_killed = 1'b0; m_valid = 1'b0;
    m_addr = '0; m_pc = '0; m_data = '0; mem_cnt = 0;
    PC = '0; pc_nx = '0;
    exp_req_q.delete();
    exp_inst_q.delete();
    repeat (n) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Monitor: consumes expectations whenever the DUT shows a transaction.
  logic prev_req = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        if (exp_req_q.size() == 0) check("unexpected_req", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("req_addr", 64'(imem_addr), 64'(exp_req_q.pop_front()));
      end
      prev_req = imem_req;
      if (inst_valid && inst_ready) begin
        if (exp_inst_q.size() == 0) check("unexpected_inst", {inst_pc, inst_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("inst_pc_data", {inst_pc, inst_data}, exp_inst_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    rst_n = 1'b0; PC = '0; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_target = '0; trap = 1'b0; inst_ready = 1'b0;
    lat_fix = 1; spur_en = 1'b0; pc_nx = '0;
    do_reset(2);

    // Back-to-back sequential fetch with single-cycle memory.
    repeat (8) cyc(0, '0, 0, 1);

    // Decode stalls: one instruction held, no new request.
    repeat (6) cyc(0, '0, 0, 0);
    repeat (4) cyc(0, '0, 0, 1);

    // Redirect during a slow read: read drained, fetch resumes at target.
    lat_fix = 3;
    guard = 0;
    while (!(m_busy && !m_killed && mem_cnt == 3) && guard < 50) begin
      cyc(0, '0, 0, 1); guard++;
    end
    check("reach_wait3", 64'(guard < 50), 64'd1);
    cyc(1, 32'h8888_8888, 0, 1);
    repeat (10) cyc(0, '0, 0, 1);

    // Trap together with redirect while an instruction is held.
    lat_fix = 1;
    guard = 0;
    while (!(m_valid && !m_busy) && guard < 50) begin
      cyc(0, '0, 0, 0); guard++;
    end
    check("reach_held", 64'(guard < 50), 64'd1);
    cyc(1, 32'h0000_1234, 1, 0);
    repeat (6) cyc(0, '0, 0, 1);

    // Redirect in the same cycle as the ack: data discarded.
    guard = 0;
    while (!(m_busy && !m_killed && mem_cnt == 1) && guard < 50) begin
      cyc(0, '0, 0, 1); guard++;
    end
    check("reach_ack", 64'(guard < 50), 64'd1);
    cyc(1, 32'h0000_0040, 0, 1);
    repeat (6) cyc(0, '0, 0, 1);

    // Reset in the middle of a read, then the boot sequence again.
    lat_fix = 4;
    guard = 0;
    while (!m_busy && guard < 50) begin
      cyc(0, '0, 0, 1); guard++;
    end
    check("reach_busy", 64'(guard < 50), 64'd1);
    cyc(0, '0, 0, 1);
    do_reset(2);
    lat_fix = 1;
    repeat (6) cyc(0, '0, 0, 1);

    // Randomised traffic: variable latency, stray acks, stalls, redirects, traps.
    lat_fix = 0;
    spur_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(99) < 8, $urandom, $urandom_range(99) < 4, $urandom_range(99) < 70);
    end
    spur_en = 1'b0;
    repeat (12) cyc(0, '0, 0, 1);

    @(negedge clk);
    #3;
    check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
    check("inst_queue_empty", 64'(exp_inst_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
